// File: rtl/bus_interface.sv
// bus_interface
// PE-side master port onto the shared CGRA bus. Captures one PE request
// (global memory read/write, local register write, local register read),
// requests the bus from the arbiter, drives the captured request while it owns
// the bus, and returns read data plus one-cycle completion strobes to the PE.
//
// Ports
//   clk, reset                      rising-edge clock, asynchronous active-low reset
//   *PE inputs                      request fields and request strobes from the PE
//   AmuxPE, BmuxPE                  returned operand / read data (held until next capture)
//   mem_ackPE, data_ReadyPE         one-cycle completion pulses to the PE
//   bus_request, grant              arbiter handshake
//   *Bus outputs                    request fields/strobes, zero unless transferring
//   AmuxBus, BmuxBus, memData       read data returned over the bus
//   mem_ackBus, data_ReadyBus       completion indications from the bus
//   execution_completeBus           registered copy of execution_completePE
module bus_interface #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] mem_addressPE,
    input  logic [DATA_W-1:0] result_inPE,
    input  logic [DATA_W-1:0] PCoutPE,
    input  logic [REG_W-1:0]  rs1OutPE,
    input  logic [REG_W-1:0]  rs2OutPE,
    input  logic [REG_W-1:0]  rdOutPE,
    input  logic              reg_selectPE,
    input  logic              mem_readPE,
    input  logic              mem_writePE,
    input  logic              rd_writePE,
    input  logic              read_enPE,
    input  logic              execution_completePE,
    output logic [DATA_W-1:0] AmuxPE,
    output logic [DATA_W-1:0] BmuxPE,
    output logic              mem_ackPE,
    output logic              data_ReadyPE,
    output logic              bus_request,
    input  logic              grant,
    output logic [DATA_W-1:0] mem_addressBus,
    output logic [DATA_W-1:0] result_outBus,
    output logic [DATA_W-1:0] PCoutBus,
    output logic [REG_W-1:0]  rs1OutBus,
    output logic [REG_W-1:0]  rs2OutBus,
    output logic [REG_W-1:0]  rdOutBus,
    output logic              reg_selectBus,
    output logic              mem_readBus,
    output logic              mem_writeBus,
    output logic              rd_writeBus,
    output logic              read_enBus,
    output logic              execution_completeBus,
    input  logic [DATA_W-1:0] AmuxBus,
    input  logic [DATA_W-1:0] BmuxBus,
    input  logic              mem_ackBus,
    input  logic              data_ReadyBus,
    input  logic [DATA_W-1:0] memData
);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, XFER = 2'd2} state_t;
    typedef enum logic [1:0] {OP_MEM_WR = 2'd0, OP_MEM_RD = 2'd1,
                              OP_REG_WR = 2'd2, OP_REG_RD = 2'd3} op_t;

    state_t            state_r;
    op_t               op_r;
    logic [DATA_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] pc_r;
    logic [REG_W-1:0]  rs1_r;
    logic [REG_W-1:0]  rs2_r;
    logic [REG_W-1:0]  rd_r;
    logic              regSel_r;

    op_t  selOp_s;
    logic anyReq_s;
    logic goXfer_s;

    // Fixed-priority choice of which pending PE request gets latched.
    always_comb begin
        anyReq_s = mem_writePE | mem_readPE | rd_writePE | read_enPE;
        if (mem_writePE) begin
            selOp_s = OP_MEM_WR;
        end else if (mem_readPE) begin
            selOp_s = OP_MEM_RD;
        end else if (rd_writePE) begin
            selOp_s = OP_REG_WR;
        end else begin
            selOp_s = OP_REG_RD;
        end
    end

    // Whether the next cycle is a transfer cycle; the bus fields are registered,
    // so they are loaded on the edge that enters or stays in XFER.
    always_comb begin
        goXfer_s = 1'b0;
        case (state_r)
            REQ: goXfer_s = grant;
            XFER: begin
                case (op_r)
                    OP_MEM_RD: goXfer_s = grant & ~mem_ackBus;
                    OP_REG_RD: goXfer_s = grant & ~data_ReadyBus;
                    default:   goXfer_s = 1'b0;
                endcase
            end
            default: goXfer_s = 1'b0;
        endcase
    end

    // Request FSM with registered bus fields, completion pulses and return data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r               <= IDLE;
            op_r                  <= OP_MEM_WR;
            addr_r                <= {DATA_W{1'b0}};
            data_r                <= {DATA_W{1'b0}};
            pc_r                  <= {DATA_W{1'b0}};
            rs1_r                 <= {REG_W{1'b0}};
            rs2_r                 <= {REG_W{1'b0}};
            rd_r                  <= {REG_W{1'b0}};
            regSel_r              <= 1'b0;
            AmuxPE                <= {DATA_W{1'b0}};
            BmuxPE                <= {DATA_W{1'b0}};
            mem_ackPE             <= 1'b0;
            data_ReadyPE          <= 1'b0;
            bus_request           <= 1'b0;
            mem_addressBus        <= {DATA_W{1'b0}};
            result_outBus         <= {DATA_W{1'b0}};
            PCoutBus              <= {DATA_W{1'b0}};
            rs1OutBus             <= {REG_W{1'b0}};
            rs2OutBus             <= {REG_W{1'b0}};
            rdOutBus              <= {REG_W{1'b0}};
            reg_selectBus         <= 1'b0;
            mem_readBus           <= 1'b0;
            mem_writeBus          <= 1'b0;
            rd_writeBus           <= 1'b0;
            read_enBus            <= 1'b0;
            execution_completeBus <= 1'b0;
        end else begin
            execution_completeBus <= execution_completePE;
            mem_ackPE             <= 1'b0;
            data_ReadyPE          <= 1'b0;

            // Bus side stays all-zero outside XFER so several masters can be OR-ed.
            if (goXfer_s) begin
                mem_addressBus <= addr_r;
                result_outBus  <= data_r;
                PCoutBus       <= pc_r;
                rs1OutBus      <= rs1_r;
                rs2OutBus      <= rs2_r;
                rdOutBus       <= rd_r;
                reg_selectBus  <= regSel_r;
                mem_writeBus   <= (op_r == OP_MEM_WR);
                mem_readBus    <= (op_r == OP_MEM_RD);
                rd_writeBus    <= (op_r == OP_REG_WR);
                read_enBus     <= (op_r == OP_REG_RD);
            end else begin
                mem_addressBus <= {DATA_W{1'b0}};
                result_outBus  <= {DATA_W{1'b0}};
                PCoutBus       <= {DATA_W{1'b0}};
                rs1OutBus      <= {REG_W{1'b0}};
                rs2OutBus      <= {REG_W{1'b0}};
                rdOutBus       <= {REG_W{1'b0}};
                reg_selectBus  <= 1'b0;
                mem_writeBus   <= 1'b0;
                mem_readBus    <= 1'b0;
                rd_writeBus    <= 1'b0;
                read_enBus     <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (anyReq_s) begin
                        addr_r      <= mem_addressPE;
                        data_r      <= result_inPE;
                        pc_r        <= PCoutPE;
                        rs1_r       <= rs1OutPE;
                        rs2_r       <= rs2OutPE;
                        rd_r        <= rdOutPE;
                        regSel_r    <= reg_selectPE;
                        op_r        <= selOp_s;
                        state_r     <= REQ;
                        bus_request <= 1'b1;
                    end else begin
                        bus_request <= 1'b0;
                    end
                end
                REQ: begin
                    bus_request <= 1'b1;
                    if (grant) begin
                        state_r <= XFER;
                    end else begin
                        state_r <= REQ;
                    end
                end
                XFER: begin
                    case (op_r)
                        // Writes are accepted only if grant was still held during the cycle.
                        OP_MEM_WR, OP_REG_WR: begin
                            if (grant) begin
                                mem_ackPE   <= (op_r == OP_MEM_WR);
                                state_r     <= IDLE;
                                bus_request <= 1'b0;
                            end else begin
                                state_r     <= REQ;
                                bus_request <= 1'b1;
                            end
                        end
                        // A completion arriving together with a grant drop still counts.
                        OP_MEM_RD: begin
                            if (mem_ackBus) begin
                                AmuxPE      <= memData;
                                mem_ackPE   <= 1'b1;
                                state_r     <= IDLE;
                                bus_request <= 1'b0;
                            end else if (!grant) begin
                                state_r     <= REQ;
                                bus_request <= 1'b1;
                            end else begin
                                state_r     <= XFER;
                                bus_request <= 1'b1;
                            end
                        end
                        default: begin
                            if (data_ReadyBus) begin
                                AmuxPE       <= AmuxBus;
                                BmuxPE       <= BmuxBus;
                                data_ReadyPE <= 1'b1;
                                state_r      <= IDLE;
                                bus_request  <= 1'b0;
                            end else if (!grant) begin
                                state_r     <= REQ;
                                bus_request <= 1'b1;
                            end else begin
                                state_r     <= XFER;
                                bus_request <= 1'b1;
                            end
                        end
                    endcase
                end
                default: begin
                    state_r     <= IDLE;
                    bus_request <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interface.sv
module tb_bus_interface;

    logic        clk;
    logic        reset;
    logic [31:0] mem_addressPE, result_inPE, PCoutPE;
    logic [4:0]  rs1OutPE, rs2OutPE, rdOutPE;
    logic        reg_selectPE, mem_readPE, mem_writePE, rd_writePE, read_enPE;
    logic        execution_completePE;
    logic [31:0] AmuxPE, BmuxPE;
    logic        mem_ackPE, data_ReadyPE, bus_request, grant;
    logic [31:0] mem_addressBus, result_outBus, PCoutBus;
    logic [4:0]  rs1OutBus, rs2OutBus, rdOutBus;
    logic        reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus;
    logic        execution_completeBus;
    logic [31:0] AmuxBus, BmuxBus, memData;
    logic        mem_ackBus, data_ReadyBus;

    bus_interface #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset),
        .mem_addressPE(mem_addressPE), .result_inPE(result_inPE), .PCoutPE(PCoutPE),
        .rs1OutPE(rs1OutPE), .rs2OutPE(rs2OutPE), .rdOutPE(rdOutPE),
        .reg_selectPE(reg_selectPE), .mem_readPE(mem_readPE), .mem_writePE(mem_writePE),
        .rd_writePE(rd_writePE), .read_enPE(read_enPE),
        .execution_completePE(execution_completePE),
        .AmuxPE(AmuxPE), .BmuxPE(BmuxPE), .mem_ackPE(mem_ackPE), .data_ReadyPE(data_ReadyPE),
        .bus_request(bus_request), .grant(grant),
        .mem_addressBus(mem_addressBus), .result_outBus(result_outBus), .PCoutBus(PCoutBus),
        .rs1OutBus(rs1OutBus), .rs2OutBus(rs2OutBus), .rdOutBus(rdOutBus),
        .reg_selectBus(reg_selectBus), .mem_readBus(mem_readBus), .mem_writeBus(mem_writeBus),
        .rd_writeBus(rd_writeBus), .read_enBus(read_enBus),
        .execution_completeBus(execution_completeBus),
        .AmuxBus(AmuxBus), .BmuxBus(BmuxBus), .mem_ackBus(mem_ackBus),
        .data_ReadyBus(data_ReadyBus), .memData(memData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe order in the scoreboard: {mem_write, mem_read, rd_write, read_en}
    typedef struct packed {
        logic [3:0]  strobes;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regSel;
        logic [31:0] amux;
        logic [31:0] bmux;
    } exp_t;

    exp_t        busQ[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] modelA = 32'h0;
    logic [31:0] modelB = 32'h0;
    int          lastLatency = 0;

    logic [115:0] busFields;
    logic [183:0] allOut;
    assign busFields = {mem_addressBus, result_outBus, PCoutBus, rs1OutBus, rs2OutBus, rdOutBus,
                        reg_selectBus, mem_readBus, mem_writeBus, rd_writeBus, read_enBus};
    assign allOut = {AmuxPE, BmuxPE, mem_ackPE, data_ReadyPE, bus_request, busFields,
                     execution_completeBus};

    task automatic checkW(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected transaction and expected PE-side return values after it completes.
    task automatic pushExp(input logic [3:0] s);
        exp_t e;
        e.strobes = s;
        e.addr    = mem_addressPE;
        e.data    = result_inPE;
        e.pc      = PCoutPE;
        e.rs1     = rs1OutPE;
        e.rs2     = rs2OutPE;
        e.rd      = rdOutPE;
        e.regSel  = reg_selectPE;
        if (s[2]) modelA = memData;
        if (s[0]) begin
            modelA = AmuxBus;
            modelB = BmuxBus;
        end
        e.amux = modelA;
        e.bmux = modelB;
        busQ.push_back(e);
    endtask

    // Acts as bus slave for one transaction and checks it against the queue head.
    task automatic serve(input int ackDelay, input bit dropGrant);
        exp_t       e;
        logic [3:0] strb;
        logic [3:0] prevStrb = 4'b0;
        bit         xferSeen = 1'b0;
        bit         dropped  = 1'b0;
        bit         done     = 1'b0;
        int         dropWait = 0;
        int         xferRun  = 0;
        int         xferTotal = 0;
        int         expCycles;
        e = '0;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            @(negedge clk);
            mem_ackBus    = 1'b0;
            data_ReadyBus = 1'b0;
            strb = {mem_writeBus, mem_readBus, rd_writeBus, read_enBus};
            if (strb != 4'b0) begin
                if (prevStrb == 4'b0) begin
                    if (!xferSeen) begin
                        if (busQ.size() == 0) begin
                            checkW("unexpectedXfer", {28'h0, strb}, 192'h0);
                        end else begin
                            e = busQ.pop_front();
                        end
                        xferSeen    = 1'b1;
                        lastLatency = cyc + 1;
                    end
                    checkW("busStrobes", {188'h0, strb}, {188'h0, e.strobes});
                    checkW("busAddr", mem_addressBus, e.addr);
                    checkW("busData", result_outBus, e.data);
                    checkW("busPC", PCoutBus, e.pc);
                    checkW("busRegs", {rs1OutBus, rs2OutBus, rdOutBus, reg_selectBus},
                           {e.rs1, e.rs2, e.rd, e.regSel});
                    xferRun = 0;
                end
                xferRun++;
                xferTotal++;
                if (dropGrant && !dropped) begin
                    grant    = 1'b0;
                    dropped  = 1'b1;
                    dropWait = 2;
                end else if (xferRun > ackDelay && grant) begin
                    if (e.strobes[2]) mem_ackBus = 1'b1;
                    if (e.strobes[0]) data_ReadyBus = 1'b1;
                end
            end else begin
                if (dropped && dropWait > 0) begin
                    if (dropWait == 2) begin
                        checkW("dropBusReq", bus_request, 1'b1);
                        checkW("dropFieldsZero", busFields, 116'h0);
                    end
                    dropWait--;
                    if (dropWait == 0) grant = 1'b1;
                end else if (xferSeen && !bus_request) begin
                    done = 1'b1;
                    expCycles = (e.strobes[3] | e.strobes[1]) ? 1 :
                                (ackDelay + 1 + (dropGrant ? 1 : 0));
                    checkW("xferCycles", xferTotal, expCycles);
                    checkW("memAckPE", mem_ackPE, e.strobes[3] | e.strobes[2]);
                    checkW("dataReadyPE", data_ReadyPE, e.strobes[0]);
                    checkW("AmuxPE", AmuxPE, e.amux);
                    checkW("BmuxPE", BmuxPE, e.bmux);
                    if (e.strobes[3]) mem_writePE = 1'b0;
                    if (e.strobes[2]) mem_readPE = 1'b0;
                    if (e.strobes[1]) rd_writePE = 1'b0;
                    if (e.strobes[0]) read_enPE = 1'b0;
                end
            end
            prevStrb = strb;
        end
        checkW("serveCompleted", done, 1'b1);
        @(negedge clk);
        checkW("ackPulseWidth", {mem_ackPE, data_ReadyPE}, 2'b00);
    endtask

    initial begin
        reset = 1'b0;
        mem_addressPE = 32'h0; result_inPE = 32'h0; PCoutPE = 32'h0;
        rs1OutPE = 5'd0; rs2OutPE = 5'd0; rdOutPE = 5'd0; reg_selectPE = 1'b0;
        mem_readPE = 1'b0; mem_writePE = 1'b0; rd_writePE = 1'b0; read_enPE = 1'b0;
        execution_completePE = 1'b0; grant = 1'b0;
        AmuxBus = 32'h0; BmuxBus = 32'h0; memData = 32'h0;
        mem_ackBus = 1'b0; data_ReadyBus = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        checkW("resetAllZero", allOut, 184'h0);
        reset = 1'b1;
        @(negedge clk);

        // Global memory write
        mem_addressPE = 32'hAABBCCDD; result_inPE = 32'h12345678; PCoutPE = 32'h00000100;
        rs1OutPE = 5'd3; rs2OutPE = 5'd4; rdOutPE = 5'd7; reg_selectPE = 1'b1;
        grant = 1'b1; mem_writePE = 1'b1;
        pushExp(4'b1000);
        serve(0, 1'b0);
        checkW("writeLatency", lastLatency, 2);

        // Global memory read with delayed acknowledge
        mem_addressPE = 32'h11223344; reg_selectPE = 1'b0; memData = 32'h87654321;
        mem_readPE = 1'b1;
        pushExp(4'b0100);
        serve(2, 1'b0);

        // Local register write; returned data must hold
        rdOutPE = 5'd10; result_inPE = 32'hFACECAFE; memData = 32'h0;
        rd_writePE = 1'b1;
        pushExp(4'b0010);
        serve(0, 1'b0);

        // Local register read
        rs1OutPE = 5'd1; rs2OutPE = 5'd2;
        AmuxBus = 32'hABCD1234; BmuxBus = 32'hDCBA4321;
        read_enPE = 1'b1;
        pushExp(4'b0001);
        serve(1, 1'b0);

        // Request pending without grant
        grant = 1'b0; mem_addressPE = 32'h55AA55AA; result_inPE = 32'h0BADF00D;
        mem_writePE = 1'b1;
        repeat (3) @(negedge clk);
        checkW("noGrantBusReq", bus_request, 1'b1);
        checkW("noGrantFieldsZero", busFields, 116'h0);
        grant = 1'b1;
        pushExp(4'b1000);
        serve(0, 1'b0);

        // Grant drop mid-read, re-issue on regrant
        mem_addressPE = 32'h0000BEEF; memData = 32'hCAFEF00D;
        mem_readPE = 1'b1;
        pushExp(4'b0100);
        serve(1, 1'b1);

        // All four requests at once: served strictly by priority
        mem_addressPE = 32'h01020304; result_inPE = 32'h0A0B0C0D; PCoutPE = 32'h00000200;
        rs1OutPE = 5'd17; rs2OutPE = 5'd31; rdOutPE = 5'd5; reg_selectPE = 1'b1;
        memData = 32'h13579BDF; AmuxBus = 32'h2468ACE0; BmuxBus = 32'hFEDCBA98;
        mem_writePE = 1'b1; mem_readPE = 1'b1; rd_writePE = 1'b1; read_enPE = 1'b1;
        pushExp(4'b1000);
        pushExp(4'b0100);
        pushExp(4'b0010);
        pushExp(4'b0001);
        for (int k = 0; k < 4; k++) serve(0, 1'b0);
        checkW("queueDrained", busQ.size(), 0);

        // execution_complete passthrough, independent of grant
        grant = 1'b0;
        execution_completePE = 1'b1;
        @(negedge clk);
        checkW("execCompleteHigh", execution_completeBus, 1'b1);
        execution_completePE = 1'b0;
        @(negedge clk);
        checkW("execCompleteLow", execution_completeBus, 1'b0);

        // Stray completions while idle are ignored
        grant = 1'b1; mem_ackBus = 1'b1; data_ReadyBus = 1'b1;
        memData = 32'h77777777; AmuxBus = 32'h66666666; BmuxBus = 32'h55555555;
        @(negedge clk);
        checkW("strayAcks", {mem_ackPE, data_ReadyPE, bus_request}, 3'b000);
        checkW("strayHoldA", AmuxPE, modelA);
        checkW("strayHoldB", BmuxPE, modelB);
        mem_ackBus = 1'b0; data_ReadyBus = 1'b0;

        // Asynchronous reset in the middle of a read transfer
        mem_addressPE = 32'h99999999; mem_readPE = 1'b1;
        for (int k = 0; k < 10 && !mem_readBus; k++) @(negedge clk);
        checkW("rstXferReached", mem_readBus, 1'b1);
        #2 reset = 1'b0;
        #1 checkW("rstMidXferZero", allOut, 184'h0);
        mem_readPE = 1'b0;
        modelA = 32'h0; modelB = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkW("postResetIdle", allOut, 184'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
